pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_if.sv | 27 ++
 rtl/pipe_stage_reg.sv | 122 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Pipeline stage bundle: the upstream side drives valid/data/ctrl plus the
// stall/flush hazard controls; the stage returns its last-stage contents and
// its occupancy count.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 31,
   parameter int CTRL_W = 5
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              stall;
   logic              flush;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [2:0]        occupancy;

   modport master (
      output in_valid, in_data, in_ctrl, stall, flush,
      input  out_valid, out_data, out_ctrl, occupancy
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, stall, flush,
      output out_valid, out_data, out_ctrl, occupancy
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-deep register pipeline carrying {valid, data, ctrl}
// between processor stages, with stall (hold) and flush (kill) controls.
// Bubbles always carry zero data/ctrl so they can never trigger a memory or
// register write downstream. Outputs come straight from the last stage.
// Optional feature: define PIPE_STAGE_REG_PERF_EN to add perf_clr and the
// saturating stall_cnt / bubble_cnt event counters.
module pipe_stage_reg #(
   parameter int DATA_W = 31,
   parameter int CTRL_W = 5,
   parameter int DEPTH  = 1
) (
   input  logic clk,
   input  logic rst_n,
`ifdef PIPE_STAGE_REG_PERF_EN
   input  logic        perf_clr,
   output logic [15:0] stall_cnt,
   output logic [15:0] bubble_cnt,
`endif
   pipe_stage_reg_if.slave bus
);

   logic              valid_r [DEPTH];
   logic [DATA_W-1:0] data_r  [DEPTH];
   logic [CTRL_W-1:0] ctrl_r  [DEPTH];
   logic              valid_s [DEPTH];
   logic [DATA_W-1:0] data_s  [DEPTH];
   logic [CTRL_W-1:0] ctrl_s  [DEPTH];
   logic [2:0]        occ_r;
   logic [2:0]        occ_s;

   // Next contents of every stage: flush beats stall, stall beats advance.
   always_comb begin
      occ_s = 3'd0;
      for (int k = 0; k < DEPTH; k++) begin
         valid_s[k] = valid_r[k];
         data_s[k]  = data_r[k];
         ctrl_s[k]  = ctrl_r[k];
      end
      if (bus.flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_s[k] = 1'b0;
            data_s[k]  = {DATA_W{1'b0}};
            ctrl_s[k]  = {CTRL_W{1'b0}};
         end
      end else if (bus.stall) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_s[k] = valid_r[k];
            data_s[k]  = data_r[k];
            ctrl_s[k]  = ctrl_r[k];
         end
      end else begin
         valid_s[0] = bus.in_valid;
         data_s[0]  = bus.in_valid ? bus.in_data : {DATA_W{1'b0}};
         ctrl_s[0]  = bus.in_valid ? bus.in_ctrl : {CTRL_W{1'b0}};
         // Older stages already hold zeroed bubbles, so a plain shift keeps
         // the zero-payload rule intact.
         for (int k = 1; k < DEPTH; k++) begin
            valid_s[k] = valid_r[k-1];
            data_s[k]  = data_r[k-1];
            ctrl_s[k]  = ctrl_r[k-1];
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         occ_s = occ_s + {2'b00, valid_s[k]};
      end
   end

   // Stage registers and registered occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_r[k] <= 1'b0;
            data_r[k]  <= {DATA_W{1'b0}};
            ctrl_r[k]  <= {CTRL_W{1'b0}};
         end
         occ_r <= 3'd0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            valid_r[k] <= valid_s[k];
            data_r[k]  <= data_s[k];
            ctrl_r[k]  <= ctrl_s[k];
         end
         occ_r <= occ_s;
      end
   end

   assign bus.out_valid = valid_r[DEPTH-1];
   assign bus.out_data  = data_r[DEPTH-1];
   assign bus.out_ctrl  = ctrl_r[DEPTH-1];
   assign bus.occupancy = occ_r;

`ifdef PIPE_STAGE_REG_PERF_EN
   logic [15:0] stall_cnt_r;
   logic [15:0] bubble_cnt_r;

   // Saturating stall/bubble event counters; perf_clr overrides counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r  <= 16'h0000;
         bubble_cnt_r <= 16'h0000;
      end else if (perf_clr) begin
         stall_cnt_r  <= 16'h0000;
         bubble_cnt_r <= 16'h0000;
      end else begin
         if (bus.stall && !bus.flush && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (!bus.stall && !valid_r[DEPTH-1] && (bubble_cnt_r != 16'hFFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 16'd1;
         end else begin
            bubble_cnt_r <= bubble_cnt_r;
         end
      end
   end

   assign stall_cnt  = stall_cnt_r;
   assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four instances (DEPTH 1..4) share one stimulus
// stream and are compared every cycle against a queue-based reference of
// the pipeline contents. Perf counters are checked when
// PIPE_STAGE_REG_PERF_EN is defined.
module tb_pipe_stage_reg;

   typedef struct packed {
      logic        v;
      logic [30:0] d;
      logic [4:0]  c;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [30:0] in_data;
   logic [4:0]  in_ctrl;
   logic        stall;
   logic        flush;
   logic        perf_clr;

   logic        obs_v  [4];
   logic [30:0] obs_d  [4];
   logic [4:0]  obs_c  [4];
   logic [2:0]  obs_o  [4];
   logic [15:0] obs_sc [4];
   logic [15:0] obs_bc [4];

   ent_t        pipe_q [4][$];
   int          stall_m;
   int          bubble_m [4];
   int          n_checks;
   int          n_fail;

   for (genvar g = 0; g < 4; g++) begin : gen_dut
      pipe_stage_reg_if #(.DATA_W(31), .CTRL_W(5)) bus ();
      assign bus.in_valid = in_valid;
      assign bus.in_data  = in_data;
      assign bus.in_ctrl  = in_ctrl;
      assign bus.stall    = stall;
      assign bus.flush    = flush;
      assign obs_v[g]     = bus.out_valid;
      assign obs_d[g]     = bus.out_data;
      assign obs_c[g]     = bus.out_ctrl;
      assign obs_o[g]     = bus.occupancy;
`ifndef PIPE_STAGE_REG_PERF_EN
      assign obs_sc[g]    = 16'h0000;
      assign obs_bc[g]    = 16'h0000;
`endif
      pipe_stage_reg #(.DATA_W(31), .CTRL_W(5), .DEPTH(g + 1)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
`ifdef PIPE_STAGE_REG_PERF_EN
         .perf_clr   (perf_clr),
         .stall_cnt  (obs_sc[g]),
         .bubble_cnt (obs_bc[g]),
`endif
         .bus        (bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      ent_t bub;
      bub = '0;
      for (int d = 0; d < 4; d++) begin
         pipe_q[d].delete();
         for (int k = 0; k <= d; k++) pipe_q[d].push_back(bub);
         bubble_m[d] = 0;
      end
      stall_m = 0;
   endtask

   task automatic compare_all();
      ent_t e;
      int   occ;
      for (int d = 0; d < 4; d++) begin
         e   = pipe_q[d][pipe_q[d].size() - 1];
         occ = 0;
         for (int k = 0; k < pipe_q[d].size(); k++) if (pipe_q[d][k].v) occ++;
         check_eq($sformatf("d%0d_out_valid", d + 1), 64'(obs_v[d]), 64'(e.v));
         check_eq($sformatf("d%0d_out_data", d + 1), 64'(obs_d[d]), 64'(e.d));
         check_eq($sformatf("d%0d_out_ctrl", d + 1), 64'(obs_c[d]), 64'(e.c));
         check_eq($sformatf("d%0d_occupancy", d + 1), 64'(obs_o[d]), 64'(occ));
`ifdef PIPE_STAGE_REG_PERF_EN
         check_eq($sformatf("d%0d_stall_cnt", d + 1), 64'(obs_sc[d]), 64'(stall_m));
         check_eq($sformatf("d%0d_bubble_cnt", d + 1), 64'(obs_bc[d]), 64'(bubble_m[d]));
`endif
      end
   endtask

   // One clock edge: the reference applies the same rules to its queues.
   task automatic step();
      ent_t nw;
      @(posedge clk);
`ifdef PIPE_STAGE_REG_PERF_EN
      for (int d = 0; d < 4; d++) begin
         if (perf_clr) bubble_m[d] = 0;
         else if (!stall && !pipe_q[d][pipe_q[d].size() - 1].v && bubble_m[d] < 65535) bubble_m[d]++;
      end
      if (perf_clr) stall_m = 0;
      else if (stall && !flush && stall_m < 65535) stall_m++;
`endif
      nw = '0;
      if (in_valid) nw = '{v: 1'b1, d: in_data, c: in_ctrl};
      for (int d = 0; d < 4; d++) begin
         if (flush) begin
            for (int k = 0; k < pipe_q[d].size(); k++) pipe_q[d][k] = '0;
         end else if (!stall) begin
            pipe_q[d].push_front(nw);
            void'(pipe_q[d].pop_back());
         end
      end
      #1;
      compare_all();
   endtask

   task automatic drive(input logic v, input logic [30:0] d, input logic [4:0] c,
                        input logic s, input logic f);
      in_valid = v;
      in_data  = d;
      in_ctrl  = c;
      stall    = s;
      flush    = f;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      perf_clr = 1'b0;
      rst_n    = 1'b0;
      drive(1'b1, 31'h5A5A, 5'h1F, 1'b0, 1'b0);
      model_reset();
      #3;
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 31'h0, 5'h0, 1'b0, 1'b0);

      // Streaming 0x11, 0x22, 0x33.
      drive(1'b1, 31'h11, 5'h01, 1'b0, 1'b0); step();
      drive(1'b1, 31'h22, 5'h02, 1'b0, 1'b0); step();
      check_eq("stream_d2_first", 64'(obs_d[1]), 64'h11);
      drive(1'b1, 31'h33, 5'h03, 1'b0, 1'b0); step();
      check_eq("stream_d2_second", 64'(obs_d[1]), 64'h22);
      check_eq("stream_d2_occ", 64'(obs_o[1]), 64'd2);
      drive(1'b0, 31'h0, 5'h0, 1'b0, 1'b0); step();
      check_eq("stream_d2_third", 64'(obs_d[1]), 64'h33);

      // Stall three cycles with garbage on the inputs, then resume.
      drive(1'b1, 31'h44, 5'h04, 1'b0, 1'b0); step();
      drive(1'b1, 31'h55, 5'h05, 1'b0, 1'b0); step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 31'h7777, 5'h1F, 1'b1, 1'b0); step();
      end
      check_eq("stall_hold_d2", 64'(obs_d[1]), 64'h44);
      drive(1'b1, 31'h66, 5'h06, 1'b0, 1'b0); step();
      check_eq("stall_resume_d2", 64'(obs_d[1]), 64'h55);

      // Fill, then flush together with stall.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 31'(32'h100 + i), 5'h0A, 1'b0, 1'b0); step();
      end
      drive(1'b1, 31'h999, 5'h1F, 1'b1, 1'b1); step();
      check_eq("flush_stall_d3_occ", 64'(obs_o[2]), 64'd0);
      check_eq("flush_stall_d3_ctrl", 64'(obs_c[2]), 64'd0);

      // Bubble with non-zero payload on the inputs.
      drive(1'b0, 31'hABC, 5'h1F, 1'b0, 1'b0); step();
      check_eq("bubble_d1_ctrl", 64'(obs_c[0]), 64'd0);
      check_eq("bubble_d1_data", 64'(obs_d[0]), 64'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 31'($urandom), 5'($urandom),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 11) == 0));
         perf_clr = 1'($urandom_range(0, 29) == 0);
         step();
      end
      perf_clr = 1'b0;

      // Asynchronous reset between edges with all stages full.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 31'(32'h200 + i), 5'h15, 1'b0, 1'b0); step();
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      check_eq("async_rst_d4_valid", 64'(obs_v[3]), 64'd0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 31'(32'h300 + i), 5'h07, 1'b0, 1'b0); step();
         if (i == 2) check_eq("restart_d4_not_yet", 64'(obs_v[3]), 64'd0);
         if (i == 3) check_eq("restart_d4_first", 64'(obs_d[3]), 64'h300);
      end

`ifdef PIPE_STAGE_REG_PERF_EN
      // Saturation: clear, count up to 0xFFFE, then two more edges.
      perf_clr = 1'b1;
      drive(1'b0, 31'h0, 5'h0, 1'b1, 1'b0); step();
      perf_clr = 1'b0;
      for (int i = 0; i < 65534; i++) step();
      check_eq("stall_cnt_preload", 64'(obs_sc[0]), 64'hFFFE);
      step();
      step();
      check_eq("stall_cnt_sat", 64'(obs_sc[0]), 64'hFFFF);
      perf_clr = 1'b1;
      step();
      check_eq("stall_cnt_clr", 64'(obs_sc[0]), 64'h0);
      perf_clr = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
